// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: generates PC, inter-stage, RAM and register-file write strobes for an N-stage datapath.
// Latency: strobes are combinational from registered state plus run/stage_busy/flush; state commits on the same edge.
// Backpressure: run=0 freezes all state with no strobes; a busy live stage stalls the token or the whole pipe.
//
// Ports:
//   clk, reset_n      - clock, synchronous active-low reset
//   mode              - 0 = sequential, 1 = overlapped; captured only while reset_n = 0
//   run               - advance allowed
//   stage_busy[N-1:0] - per-stage "needs more cycles"
//   flush             - branch taken at FLUSH_STAGE (overlapped mode only)
//   pc_wren, stage_wren[N-2:0], ram_wren, reg_wren - write strobes
//   stage_reset_n     - registered active-low reset for the pipeline registers
//   retire_count      - committed writebacks, wraps at 2^32
module pipeline_sequencer #(
  parameter int NUM_STAGES   = 5,
  parameter int MEM_STAGE    = 3,
  parameter int FLUSH_STAGE  = 3,
  parameter int RESET_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mode,
  input  logic                  run,
  input  logic [NUM_STAGES-1:0] stage_busy,
  input  logic                  flush,
  output logic                  pc_wren,
  output logic [NUM_STAGES-2:0] stage_wren,
  output logic                  ram_wren,
  output logic                  reg_wren,
  output logic                  stage_reset_n,
  output logic [31:0]           retire_count
);

  localparam int              CW      = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0]   RC_INIT = CW'(RESET_CYCLES);
  localparam logic [NUM_STAGES-1:0] TOKEN_INIT = {{(NUM_STAGES-1){1'b0}}, 1'b1};

  logic                  r_mode;
  logic [NUM_STAGES-1:0] r_token;
  logic [NUM_STAGES-1:0] r_valid;
  logic [CW-1:0]         r_rst_cnt;
  logic                  r_stage_rst_n;
  logic [31:0]           r_retire;

  logic                  w_en;
  logic                  w_tok_busy;
  logic                  w_stall;
  logic                  w_seq_go;
  logic                  w_adv;
  logic                  w_flush_hit;
  logic [NUM_STAGES-1:0] w_valid_nxt;

  always_comb begin
    w_en        = reset_n & r_stage_rst_n & run;
    // Only the busy bit of the stage holding the token matters in sequential mode.
    w_tok_busy  = |(r_token & stage_busy);
    // Only live stages can stall the overlapped pipe.
    w_stall     = |(r_valid & stage_busy);
    w_seq_go    = w_en & ~r_mode & ~w_tok_busy;
    w_adv       = w_en & r_mode & ~w_stall;
    w_flush_hit = flush & r_valid[FLUSH_STAGE];

    // Flush squashes everything younger than the resolving stage; the branch itself moves on.
    w_valid_nxt    = '0;
    w_valid_nxt[0] = 1'b1;
    for (int i = 1; i < NUM_STAGES; i++) begin
      w_valid_nxt[i] = r_valid[i-1] & ~(w_flush_hit & (i <= FLUSH_STAGE));
    end
  end

  always_comb begin
    pc_wren  = w_adv | (w_seq_go & r_token[NUM_STAGES-1]);
    ram_wren = (w_adv & r_valid[MEM_STAGE]) | (w_seq_go & r_token[MEM_STAGE]);
    reg_wren = (w_adv & r_valid[NUM_STAGES-1]) | (w_seq_go & r_token[NUM_STAGES-1]);
    if (w_adv) begin
      stage_wren = '1;
    end else if (w_seq_go) begin
      stage_wren = r_token[NUM_STAGES-2:0];
    end else begin
      stage_wren = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mode        <= mode;
      r_token       <= TOKEN_INIT;
      r_valid       <= '0;
      r_rst_cnt     <= RC_INIT;
      r_stage_rst_n <= 1'b0;
      r_retire      <= '0;
    end else begin
      if (r_rst_cnt == '0) begin
        r_stage_rst_n <= 1'b1;
      end else begin
        r_rst_cnt <= r_rst_cnt - 1'b1;
      end
      if (w_seq_go) begin
        r_token <= {r_token[NUM_STAGES-2:0], r_token[NUM_STAGES-1]};
      end
      if (w_adv) begin
        r_valid <= w_valid_nxt;
      end
      // reg_wren is exactly the commit condition in both modes.
      if (reg_wren) begin
        r_retire <= r_retire + 32'd1;
      end
    end
  end

  assign stage_reset_n = r_stage_rst_n;
  assign retire_count  = r_retire;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Testbench for pipeline_sequencer (N=5, MEM=3, FLUSH=3, RESET_CYCLES=2).
// Directed per-cycle vectors push expected strobes into a queue; a negedge monitor pops and compares.
// Covers reset exit, sequential run/stall/halt, mode lock, mid-run reset, overlapped fill/stall/flush/halt.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mode;
  logic        run;
  logic [4:0]  stage_busy;
  logic        flush;
  logic        pc_wren;
  logic [3:0]  stage_wren;
  logic        ram_wren;
  logic        reg_wren;
  logic        stage_reset_n;
  logic [31:0] retire_count;

  typedef struct {
    string       nm;
    logic [7:0]  strb;   // {pc, stage_wren[3:0], ram, reg, stage_reset_n}
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipeline_sequencer #(
    .NUM_STAGES(5), .MEM_STAGE(3), .FLUSH_STAGE(3), .RESET_CYCLES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .run(run),
    .stage_busy(stage_busy), .flush(flush),
    .pc_wren(pc_wren), .stage_wren(stage_wren), .ram_wren(ram_wren),
    .reg_wren(reg_wren), .stage_reset_n(stage_reset_n), .retire_count(retire_count)
  );

  // Advance one edge, drive this cycle's inputs and queue the outputs expected during it.
  task automatic cyc(input string nm, input logic rn, input logic r, input logic [4:0] bz,
                     input logic fl, input logic e_pc, input logic [3:0] e_sw, input logic e_ram,
                     input logic e_reg, input logic e_srst, input int e_ret);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n    = rn;
    run        = r;
    stage_busy = bz;
    flush      = fl;
    e.nm   = nm;
    e.strb = {e_pc, e_sw, e_ram, e_reg, e_srst};
    e.ret  = e_ret;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = exp_q.pop_front();
      act = {pc_wren, stage_wren, ram_wren, reg_wren, stage_reset_n};
      n_cmp++;
      if (act !== e.strb || retire_count !== e.ret) begin
        n_bad++;
        $display("FAIL %s: got strb=%b retire=%0d, expected strb=%b retire=%0d",
                 e.nm, act, retire_count, e.strb, e.ret);
      end
    end
  end

  initial begin
    int k;
    reset_n = 1'b0; mode = 1'b0; run = 1'b1; stage_busy = '0; flush = 1'b0;
    repeat (2) @(posedge clk);

    // Reset exit: stage_reset_n low for 3 cycles after reset_n rises.
    for (int i = 0; i < 3; i++) cyc("rst_exit", 1, 1, 5'b0, 0, 0, 4'b0000, 0, 0, 0, 0);

    // Sequential: 20 enabled cycles, token walks 0..4.
    for (int i = 0; i < 20; i++) begin
      k = i % 5;
      cyc("seq_run", 1, 1, 5'b0, 0, k == 4, (k < 4) ? 4'(1 << k) : 4'b0000,
          k == 3, k == 4, 1, i / 5);
    end

    // Busy on a stage not holding the token is ignored.
    cyc("seq_busy_inactive", 1, 1, 5'b01000, 0, 0, 4'b0001, 0, 0, 1, 4);
    cyc("seq_busy_inactive", 1, 1, 5'b01000, 0, 0, 4'b0010, 0, 0, 1, 4);
    cyc("seq_busy_inactive", 1, 1, 5'b01000, 0, 0, 4'b0100, 0, 0, 1, 4);
    // Token at stage 3 busy for 3 cycles; stage-1 busy alongside it is ignored.
    for (int i = 0; i < 3; i++) cyc("seq_stall", 1, 1, 5'b01010, 0, 0, 4'b0000, 0, 0, 1, 4);
    cyc("seq_stall_release", 1, 1, 5'b00010, 0, 0, 4'b1000, 1, 0, 1, 4);
    cyc("seq_wb", 1, 1, 5'b0, 0, 1, 4'b0000, 0, 1, 1, 4);

    // Halt at stage 0, resume where it left off.
    for (int i = 0; i < 4; i++) cyc("seq_halt", 1, 0, 5'b0, 0, 0, 4'b0000, 0, 0, 1, 5);
    cyc("seq_resume", 1, 1, 5'b0, 0, 0, 4'b0001, 0, 0, 1, 5);
    cyc("seq_resume", 1, 1, 5'b0, 0, 0, 4'b0010, 0, 0, 1, 5);
    cyc("seq_flush_ignored", 1, 1, 5'b0, 1, 0, 4'b0100, 0, 0, 1, 5);
    // Mode input changes after reset have no effect.
    mode = 1'b1;
    cyc("seq_mode_locked", 1, 1, 5'b0, 0, 0, 4'b1000, 1, 0, 1, 5);
    cyc("seq_mode_locked", 1, 1, 5'b0, 0, 1, 4'b0000, 0, 1, 1, 5);
    cyc("seq_wrap", 1, 1, 5'b0, 0, 0, 4'b0001, 0, 0, 1, 6);

    // Mid-run reset with busy and run=0; mode=1 is captured here.
    cyc("mid_reset", 0, 0, 5'b11111, 0, 0, 4'b0000, 0, 0, 1, 6);
    for (int i = 0; i < 3; i++) cyc("ovl_rst_exit", 1, 1, 5'b0, 0, 0, 4'b0000, 0, 0, 0, 0);

    // Overlapped fill: ram from advance 5, writeback from advance 6.
    for (int n = 1; n <= 14; n++) begin
      cyc("ovl_fill", 1, 1, 5'b0, 0, 1, 4'b1111, n >= 5, n >= 6, 1, (n >= 6) ? n - 6 : 0);
    end

    // Stall with valid[3]=1; flush during stall is dropped.
    cyc("ovl_stall", 1, 1, 5'b01000, 0, 0, 4'b0000, 0, 0, 1, 9);
    cyc("ovl_stall_flush", 1, 1, 5'b01000, 1, 0, 4'b0000, 0, 0, 1, 9);
    cyc("ovl_stall_release", 1, 1, 5'b0, 0, 1, 4'b1111, 1, 1, 1, 9);
    cyc("ovl_full", 1, 1, 5'b0, 0, 1, 4'b1111, 1, 1, 1, 10);

    // Flush on a full pipe: valid 11111 -> 10001.
    cyc("ovl_flush", 1, 1, 5'b0, 1, 1, 4'b1111, 1, 1, 1, 11);
    cyc("ovl_post_flush", 1, 1, 5'b0, 0, 1, 4'b1111, 0, 1, 1, 12);
    cyc("ovl_busy_invalid", 1, 1, 5'b01000, 0, 1, 4'b1111, 0, 0, 1, 13);
    cyc("ovl_flush_invalid", 1, 1, 5'b0, 1, 1, 4'b1111, 0, 0, 1, 13);
    cyc("ovl_refill", 1, 1, 5'b0, 0, 1, 4'b1111, 1, 0, 1, 13);
    cyc("ovl_refill", 1, 1, 5'b0, 0, 1, 4'b1111, 1, 1, 1, 13);

    // Halt in overlapped mode, then resume with a full pipe.
    for (int i = 0; i < 4; i++) cyc("ovl_halt", 1, 0, 5'b0, 0, 0, 4'b0000, 0, 0, 1, 14);
    cyc("ovl_resume", 1, 1, 5'b0, 0, 1, 4'b1111, 1, 1, 1, 14);
    cyc("ovl_resume", 1, 1, 5'b0, 0, 1, 4'b1111, 1, 1, 1, 15);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
